// File: rtl/dut_batch_sequencer_if.sv
// Core-side handshake between the batch sequencer (master) and the crypto core (slave).
interface dut_batch_sequencer_if #(
    parameter int unsigned pDATA_WIDTH = 128,
    parameter int unsigned pKEY_WIDTH  = 128
);
    logic                   core_start;
    logic [pDATA_WIDTH-1:0] core_data_in;
    logic [pKEY_WIDTH-1:0]  core_key;
    logic                   core_done;
    logic [pDATA_WIDTH-1:0] core_data_out;

    modport master (
        output core_start, core_data_in, core_key,
        input  core_done, core_data_out
    );

    modport slave (
        input  core_start, core_data_in, core_key,
        output core_done, core_data_out
    );
endinterface

// File: rtl/dut_batch_sequencer.sv
// Batch sequencer: issues a run of crypto-core operations, optionally chaining
// ciphertext back as plaintext, places a delayed capture trigger around each
// operation and bounds every run with a timeout. All outputs are registered.
module dut_batch_sequencer #(
    parameter int unsigned pDATA_WIDTH     = 128,
    parameter int unsigned pKEY_WIDTH      = 128,
    parameter int unsigned pCNT_WIDTH      = 16,
    parameter int unsigned pTIMEOUT_CYCLES = 1023
) (
    input  logic                   dut_clk,
    input  logic                   dut_rst,
    input  logic                   seq_start,
    input  logic                   seq_abort,
    input  logic [pCNT_WIDTH-1:0]  cfg_batch_count,
    input  logic                   cfg_chain,
    input  logic [7:0]             cfg_trig_delay,
    input  logic [pDATA_WIDTH-1:0] seq_data_in,
    input  logic [pKEY_WIDTH-1:0]  seq_key_in,
    dut_batch_sequencer_if.master  core,
    output logic                   trig_out,
    output logic                   seq_busy,
    output logic                   seq_done,
    output logic                   seq_timeout,
    output logic [pCNT_WIDTH-1:0]  seq_run_count,
    output logic [pDATA_WIDTH-1:0] seq_data_out
);

    localparam int unsigned     TO_W    = $clog2(pTIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(pTIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_NEXT,
        S_FINISH
    } state_t;

    state_t                 state_q;
    logic                   start_q;
    logic [pDATA_WIDTH-1:0] data_in_q;
    logic [pKEY_WIDTH-1:0]  key_q;
    logic                   trig_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   timeout_q;
    logic [pCNT_WIDTH-1:0]  run_cnt_q;
    logic [pDATA_WIDTH-1:0] data_out_q;
    logic [pCNT_WIDTH-1:0]  remaining_q;
    logic                   chain_q;
    logic [7:0]             delay_q;
    logic [7:0]             dcnt_q;
    logic [TO_W-1:0]        tcnt_q;

    // Batch FSM with all outputs registered alongside the state.
    always_ff @(posedge dut_clk) begin
        if (dut_rst) begin
            state_q     <= S_IDLE;
            start_q     <= 1'b0;
            data_in_q   <= '0;
            key_q       <= '0;
            trig_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            run_cnt_q   <= '0;
            data_out_q  <= '0;
            remaining_q <= '0;
            chain_q     <= 1'b0;
            delay_q     <= '0;
            dcnt_q      <= '0;
            tcnt_q      <= '0;
        end else begin
            start_q <= 1'b0;
            done_q  <= 1'b0;
            if (state_q != S_IDLE && seq_abort) begin
                // Abort beats core_done and timeout; captured results are kept.
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
                trig_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (seq_start && !seq_abort) begin
                            data_in_q   <= seq_data_in;
                            key_q       <= seq_key_in;
                            remaining_q <= (cfg_batch_count == '0) ? pCNT_WIDTH'(1) : cfg_batch_count;
                            run_cnt_q   <= '0;
                            timeout_q   <= 1'b0;
                            chain_q     <= cfg_chain;
                            delay_q     <= cfg_trig_delay;
                            busy_q      <= 1'b1;
                            start_q     <= 1'b1;
                            state_q     <= S_ISSUE;
                        end
                    end
                    S_ISSUE: begin
                        dcnt_q  <= '0;
                        tcnt_q  <= '0;
                        // A zero delay puts the trigger on the very first WAIT cycle.
                        trig_q  <= (delay_q == 8'd0);
                        state_q <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (core.core_done) begin
                            data_out_q  <= core.core_data_out;
                            run_cnt_q   <= run_cnt_q + pCNT_WIDTH'(1);
                            remaining_q <= remaining_q - pCNT_WIDTH'(1);
                            trig_q      <= 1'b0;
                            if (chain_q) begin
                                data_in_q <= core.core_data_out;
                            end
                            if (remaining_q == pCNT_WIDTH'(1)) begin
                                done_q  <= 1'b1;
                                state_q <= S_FINISH;
                            end else begin
                                state_q <= S_NEXT;
                            end
                        end else if (tcnt_q == TO_LAST) begin
                            timeout_q <= 1'b1;
                            trig_q    <= 1'b0;
                            done_q    <= 1'b1;
                            state_q   <= S_FINISH;
                        end else begin
                            tcnt_q <= tcnt_q + TO_W'(1);
                            if (dcnt_q != 8'hFF) begin
                                dcnt_q <= dcnt_q + 8'd1;
                            end
                            // Compare one ahead so the registered trigger lands on T+1+d.
                            if ({1'b0, dcnt_q} + 9'd1 == {1'b0, delay_q}) begin
                                trig_q <= 1'b1;
                            end
                        end
                    end
                    S_NEXT: begin
                        start_q <= 1'b1;
                        state_q <= S_ISSUE;
                    end
                    S_FINISH: begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                    default: begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign core.core_start   = start_q;
    assign core.core_data_in = data_in_q;
    assign core.core_key     = key_q;
    assign trig_out          = trig_q;
    assign seq_busy          = busy_q;
    assign seq_done          = done_q;
    assign seq_timeout       = timeout_q;
    assign seq_run_count     = run_cnt_q;
    assign seq_data_out      = data_out_q;

endmodule

// File: tb/tb_dut_batch_sequencer.sv
// Self-checking bench for dut_batch_sequencer: a behavioural crypto-core model
// plus a cycle-timeline reference model derived from the batch timing rules.
module tb_dut_batch_sequencer;

    localparam int DW = 128;
    localparam int KW = 128;
    localparam int CW = 16;
    localparam int P  = 1023;

    logic          clk = 1'b0;
    logic          dut_rst, seq_start, seq_abort, cfg_chain;
    logic [CW-1:0] cfg_batch_count;
    logic [7:0]    cfg_trig_delay;
    logic [DW-1:0] seq_data_in, seq_data_out;
    logic [KW-1:0] seq_key_in;
    logic          trig_out, seq_busy, seq_done, seq_timeout;
    logic [CW-1:0] seq_run_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Core model controls and state
    int            core_lat   = 10;
    bit            core_never = 1'b0;
    bit            fmode      = 1'b0;
    logic          model_done = 1'b0;
    logic          force_done = 1'b0;
    logic [DW-1:0] model_dout = '0;
    logic [DW-1:0] force_dout = '0;
    logic [DW-1:0] m_data     = '0;
    bit            m_busy     = 1'b0;
    int            m_cnt      = 0;

    typedef struct packed {
        logic          st;
        logic          tr;
        logic          bz;
        logic          dn;
        logic [CW-1:0] cnt;
    } exp_t;

    dut_batch_sequencer_if #(.pDATA_WIDTH(DW), .pKEY_WIDTH(KW)) bus ();

    assign bus.core_done     = model_done | force_done;
    assign bus.core_data_out = force_done ? force_dout : model_dout;

    dut_batch_sequencer #(
        .pDATA_WIDTH(DW), .pKEY_WIDTH(KW), .pCNT_WIDTH(CW), .pTIMEOUT_CYCLES(P)
    ) dut (
        .dut_clk(clk), .dut_rst(dut_rst), .seq_start(seq_start), .seq_abort(seq_abort),
        .cfg_batch_count(cfg_batch_count), .cfg_chain(cfg_chain), .cfg_trig_delay(cfg_trig_delay),
        .seq_data_in(seq_data_in), .seq_key_in(seq_key_in), .core(bus),
        .trig_out(trig_out), .seq_busy(seq_busy), .seq_done(seq_done), .seq_timeout(seq_timeout),
        .seq_run_count(seq_run_count), .seq_data_out(seq_data_out)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [DW-1:0] core_f(input logic [DW-1:0] x);
        return fmode ? (x * 128'd5 + 128'd1) : (x + 128'd1);
    endfunction

    // Crypto core: done exactly core_lat cycles after the cycle core_start is seen.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            model_done = 1'b0;
            if (m_busy) begin
                m_cnt++;
                if (m_cnt == core_lat && !core_never) begin
                    model_done = 1'b1;
                    model_dout = core_f(m_data);
                    m_busy     = 1'b0;
                end
            end
            if (bus.core_start) begin
                m_busy = 1'b1;
                m_cnt  = 0;
                m_data = bus.core_data_in;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Expected outputs r cycles after the accepted start (r=1 is the first core_start).
    // Run k starts at 1+k*(lat+2); trigger spans [t+1+d, t+lat]; FINISH one cycle after last done.
    function automatic exp_t model(input int r, input int n, input int lat, input int d, input int abort_r);
        exp_t e;
        int   pitch, last, rr, t;
        e     = '0;
        pitch = lat + 2;
        last  = 1 + (n - 1) * pitch + lat + 1;
        rr    = (abort_r >= 0 && r > abort_r) ? abort_r : r;
        for (int k = 0; k < n; k++) begin
            t = 1 + k * pitch;
            if (t + lat + 1 <= rr) e.cnt = e.cnt + 16'd1;
            if (rr == r) begin
                if (r == t) e.st = 1'b1;
                if (r >= t + 1 + d && r <= t + lat) e.tr = 1'b1;
            end
        end
        if (rr == r) begin
            e.bz = (r >= 1 && r <= last);
            e.dn = (r == last);
        end
        return e;
    endfunction

    // Runs one batch from an IDLE cycle and checks every cycle against the model.
    // Returns in the first IDLE cycle (or abort_r+8) without advancing further.
    task automatic run_batch(input int nb, input bit ch, input int d, input int lat,
                             input logic [DW-1:0] pt, input logic [KW-1:0] key,
                             input int abort_r, input bit pokes);
        int            n, pitch, last, rend, k, idx;
        logic [DW-1:0] pts[16];
        logic [DW-1:0] res[16];
        exp_t          e;
        n     = (nb == 0) ? 1 : nb;
        pitch = lat + 2;
        last  = 1 + (n - 1) * pitch + lat + 1;
        rend  = (abort_r >= 0) ? abort_r + 8 : last + 1;
        pts[0] = pt;
        for (int j = 0; j < n; j++) begin
            res[j] = core_f(pts[j]);
            if (j + 1 < n) pts[j+1] = ch ? res[j] : pt;
        end
        core_lat = lat; core_never = 1'b0; force_done = 1'b0; seq_abort = 1'b0;
        cfg_batch_count = CW'(nb); cfg_chain = ch; cfg_trig_delay = 8'(d);
        seq_data_in = pt; seq_key_in = key; seq_start = 1'b1;
        tick();
        seq_start = 1'b0;
        for (int r = 1; r <= rend; r++) begin
            e = model(r, n, lat, d, abort_r);
            n_checks++;
            if ({bus.core_start, trig_out, seq_busy, seq_done} !== {e.st, e.tr, e.bz, e.dn}) begin
                n_fail++;
                $display("FAIL ctl r=%0d start/trig/busy/done got %b exp %b", r,
                         {bus.core_start, trig_out, seq_busy, seq_done}, {e.st, e.tr, e.bz, e.dn});
            end
            n_checks++;
            if (seq_run_count !== e.cnt) begin
                n_fail++;
                $display("FAIL run_count r=%0d got %0d exp %0d", r, seq_run_count, e.cnt);
            end
            n_checks++;
            if (seq_timeout !== 1'b0) begin
                n_fail++;
                $display("FAIL timeout_flag r=%0d got %b exp 0", r, seq_timeout);
            end
            n_checks++;
            if (bus.core_key !== key) begin
                n_fail++;
                $display("FAIL core_key r=%0d got %h exp %h", r, bus.core_key, key);
            end
            if (e.st) begin
                k = (r - 1) / pitch;
                n_checks++;
                if (bus.core_data_in !== pts[k]) begin
                    n_fail++;
                    $display("FAIL core_data_in run=%0d got %h exp %h", k, bus.core_data_in, pts[k]);
                end
            end
            if (e.cnt != 0) begin
                idx = int'(e.cnt) - 1;
                n_checks++;
                if (seq_data_out !== res[idx]) begin
                    n_fail++;
                    $display("FAIL data_out r=%0d got %h exp %h", r, seq_data_out, res[idx]);
                end
            end
            seq_abort  = (r == abort_r);
            seq_start  = 1'b0;
            force_done = 1'b0;
            if (pokes && r < rend) begin
                cfg_batch_count = CW'($urandom_range(0, 9));
                cfg_chain       = $urandom_range(0, 1) != 0;
                cfg_trig_delay  = 8'($urandom_range(0, 255));
                seq_data_in     = rand128();
                seq_key_in      = rand128();
                if (r >= 2 && r <= last && $urandom_range(0, 3) == 0) seq_start = 1'b1;
                if (r < last && ((r - 1) % pitch == 0 || (r - lat - 2 >= 0 && (r - lat - 2) % pitch == 0))
                    && $urandom_range(0, 1) == 0) begin
                    force_done = 1'b1;
                    force_dout = rand128();
                end
            end
            if (r < rend) tick();
        end
        seq_abort = 1'b0; seq_start = 1'b0; force_done = 1'b0;
    endtask

    task automatic test_reset();
        dut_rst = 1'b1;
        repeat (3) tick();
        n_checks++;
        if ({bus.core_start, bus.core_data_in, bus.core_key, trig_out, seq_busy, seq_done,
             seq_timeout, seq_run_count, seq_data_out} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got busy=%b cnt=%0d din=%h", seq_busy, seq_run_count, bus.core_data_in);
        end
        dut_rst = 1'b0;
        tick();
        n_checks++;
        if ({bus.core_start, trig_out, seq_busy, seq_done, seq_run_count, seq_data_out} !== '0) begin
            n_fail++;
            $display("FAIL idle_after_reset got busy=%b start=%b", seq_busy, bus.core_start);
        end
    endtask

    task automatic test_single_run();
        logic [DW-1:0] pt;
        pt    = 128'h00112233445566778899aabbccddeeff;
        fmode = 1'b1;
        run_batch(1, 1'b0, 0, 10, pt, rand128(), -1, 1'b0);
        n_checks++;
        if (seq_data_out !== pt * 128'd5 + 128'd1 || seq_run_count !== 16'd1) begin
            n_fail++;
            $display("FAIL single_result got %h/%0d exp %h/1", seq_data_out, seq_run_count, pt * 128'd5 + 128'd1);
        end
    endtask

    task automatic test_chain();
        fmode = 1'b0;
        run_batch(4, 1'b1, 0, 10, 128'd5, rand128(), -1, 1'b0);
        n_checks++;
        if (seq_data_out !== 128'd9 || seq_run_count !== 16'd4) begin
            n_fail++;
            $display("FAIL chain_result got %0d/%0d exp 9/4", seq_data_out, seq_run_count);
        end
    endtask

    task automatic test_trig_delay();
        fmode = 1'b0;
        run_batch(1, 1'b0, 3, 10, rand128(), rand128(), -1, 1'b0);
        run_batch(2, 1'b0, 20, 10, rand128(), rand128(), -1, 1'b0);
        run_batch(1, 1'b0, 255, 12, rand128(), rand128(), -1, 1'b0);
    endtask

    task automatic test_batch_zero();
        run_batch(0, 1'b1, 1, 4, rand128(), rand128(), -1, 1'b0);
        n_checks++;
        if (seq_run_count !== 16'd1) begin
            n_fail++;
            $display("FAIL batch_zero_count got %0d exp 1", seq_run_count);
        end
    endtask

    task automatic test_timeout();
        int d, starts;
        exp_t e;
        d      = $urandom_range(0, 40);
        starts = 0;
        core_never = 1'b1; force_done = 1'b0; seq_abort = 1'b0;
        cfg_batch_count = 16'd3; cfg_chain = 1'b0; cfg_trig_delay = 8'(d);
        seq_data_in = rand128(); seq_key_in = rand128(); seq_start = 1'b1;
        tick();
        seq_start = 1'b0;
        for (int r = 1; r <= P + 4; r++) begin
            e    = '0;
            e.st = (r == 1);
            e.tr = (r >= 2 + d && r <= P + 1);
            e.bz = (r <= P + 2);
            e.dn = (r == P + 2);
            n_checks++;
            if ({bus.core_start, trig_out, seq_busy, seq_done, seq_run_count} !== {e.st, e.tr, e.bz, e.dn, 16'd0}) begin
                n_fail++;
                $display("FAIL timeout_ctl r=%0d start/trig/busy/done got %b exp %b cnt=%0d", r,
                         {bus.core_start, trig_out, seq_busy, seq_done}, {e.st, e.tr, e.bz, e.dn}, seq_run_count);
            end
            n_checks++;
            if (seq_timeout !== (r >= P + 2)) begin
                n_fail++;
                $display("FAIL timeout_flag r=%0d got %b exp %b", r, seq_timeout, (r >= P + 2));
            end
            if (bus.core_start) starts++;
            tick();
        end
        n_checks++;
        if (starts != 1) begin
            n_fail++;
            $display("FAIL timeout_starts got %0d exp 1", starts);
        end
        // A fresh batch clears the sticky flag; run_batch checks it every cycle.
        run_batch(1, 1'b0, 0, 6, rand128(), rand128(), -1, 1'b0);
    endtask

    task automatic test_abort();
        logic [DW-1:0] pt;
        pt    = rand128();
        fmode = 1'b0;
        // Abort in cycle T+5 of run 2 (T = 1 + 12) of a 5-run chained batch.
        run_batch(5, 1'b1, 0, 10, pt, rand128(), 18, 1'b0);
        n_checks++;
        if (seq_run_count !== 16'd1 || seq_data_out !== pt + 128'd1 || seq_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_retain got cnt=%0d data=%h busy=%b exp 1/%h/0", seq_run_count, seq_data_out, seq_busy, pt + 128'd1);
        end
        // Abort in the same cycle as core_done: abort wins, nothing captured.
        run_batch(3, 1'b0, 2, 10, rand128(), rand128(), 11, 1'b0);
        n_checks++;
        if (seq_run_count !== 16'd0) begin
            n_fail++;
            $display("FAIL abort_vs_done got %0d exp 0", seq_run_count);
        end
    endtask

    task automatic test_reset_mid();
        core_lat = 10; core_never = 1'b0; force_done = 1'b0; seq_abort = 1'b0;
        cfg_batch_count = 16'd2; cfg_chain = 1'b1; cfg_trig_delay = 8'd0;
        seq_data_in = rand128() | 128'd1; seq_key_in = rand128() | 128'd1; seq_start = 1'b1;
        tick();
        seq_start = 1'b0;
        repeat (4) tick();
        dut_rst = 1'b1;
        tick();
        dut_rst = 1'b0;
        n_checks++;
        if ({bus.core_start, bus.core_data_in, bus.core_key, trig_out, seq_busy, seq_done,
             seq_timeout, seq_run_count, seq_data_out} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid got busy=%b trig=%b key=%h din=%h", seq_busy, trig_out, bus.core_key, bus.core_data_in);
        end
        // The core's late done lands while IDLE and must be ignored.
        for (int r = 0; r < 10; r++) begin
            tick();
            n_checks++;
            if ({seq_busy, trig_out, seq_done, seq_run_count, seq_data_out} !== '0) begin
                n_fail++;
                $display("FAIL idle_done_ignored r=%0d got busy=%b cnt=%0d data=%h", r, seq_busy, seq_run_count, seq_data_out);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            fmode = $urandom_range(0, 1) != 0;
            run_batch($urandom_range(0, 5), $urandom_range(0, 1) != 0, $urandom_range(0, 15),
                      $urandom_range(1, 12), rand128(), rand128(), -1, 1'b1);
        end
    endtask

    initial begin
        dut_rst = 1'b1; seq_start = 1'b0; seq_abort = 1'b0; cfg_chain = 1'b0;
        cfg_batch_count = '0; cfg_trig_delay = '0; seq_data_in = '0; seq_key_in = '0;
        test_reset();
        test_single_run();
        test_chain();
        test_trig_delay();
        test_batch_zero();
        test_timeout();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
